video_fetcher: RTL and testbench

// Wishbone bus master fetching one scanline of frame-buffer words into a dual-bank line buffer.

---
 rtl/video_fetcher.sv | 218 +++++++++++++++++++++
 tb/tb_video_fetcher.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetcher.sv
// ---------------------------------------------------------------------------
// video_fetcher
// Wishbone read master that fetches one scanline of frame-buffer words into
// a dual-bank line buffer. The CRTC's line trigger starts a fetch into the
// bank selected by odd_i. The pixel feeder reads the other bank, so fetch
// and display run concurrently.
//
// Ports
//   dotclk_i, reset_i      clock (rising edge) and asynchronous active-high reset
//   frame_i                frame-start pulse; reloads the line pointer from base_adr_i
//   start_i, odd_i, len_i  line fetch request: target bank and word count
//   base_adr_i, stride_i   frame base word address and line-to-line stride
//   cyc_o, stb_o, we_o,    Wishbone master (classic cycle, read only)
//   adr_o, dat_i, ack_i, err_i
//   lb_we_o, lb_adr_o,     line-buffer write port; lb_adr_o = {bank, index}
//   lb_dat_o
//   busy_o, done_o         fetch in progress / line completed pulse
//   overrun_o, err_o       sticky: start while busy / bus error seen
// ---------------------------------------------------------------------------
module video_fetcher #(
    parameter int AW  = 24,
    parameter int DW  = 16,
    parameter int LBW = 8
) (
    input  logic           dotclk_i,
    input  logic           reset_i,
    input  logic           frame_i,
    input  logic           start_i,
    input  logic           odd_i,
    input  logic [AW-1:0]  base_adr_i,
    input  logic [AW-1:0]  stride_i,
    input  logic [LBW-1:0] len_i,
    output logic           cyc_o,
    output logic           stb_o,
    output logic           we_o,
    output logic [AW-1:0]  adr_o,
    input  logic [DW-1:0]  dat_i,
    input  logic           ack_i,
    input  logic           err_i,
    output logic           lb_we_o,
    output logic [LBW:0]   lb_adr_o,
    output logic [DW-1:0]  lb_dat_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           overrun_o,
    output logic           err_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [AW-1:0]  r_ptr;
    logic [AW-1:0]  r_adr;
    logic [LBW-1:0] r_cnt;
    logic [LBW-1:0] r_idx;
    logic           r_bank;
    logic           r_cyc;
    logic           r_lb_we;
    logic [LBW:0]   r_lb_adr;
    logic [DW-1:0]  r_lb_dat;
    logic           r_done;
    logic           r_overrun;
    logic           r_err;

    logic           w_start_ok;
    logic           w_len_zero;
    logic           w_term;
    logic           w_last;
    logic [AW-1:0]  w_line_adr;
    logic           w_cyc_nxt;
    logic           w_done_nxt;

    assign w_start_ok = start_i & (r_state == ST_IDLE);
    assign w_len_zero = (len_i == {LBW{1'b0}});
    // Bus handshake only counts while a cycle is open; stray ack/err are ignored.
    assign w_term     = r_cyc & (ack_i | err_i);
    assign w_last     = w_term & (r_cnt == LBW'(1));
    // A frame pulse coincident with start makes the line begin at the base.
    assign w_line_adr = frame_i ? base_adr_i : r_ptr;

    // State register
    always_ff @(posedge dotclk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !w_len_zero) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered bus-cycle and done outputs
    always_comb begin
        w_cyc_nxt  = r_cyc;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_cyc_nxt  = !w_len_zero;
                    w_done_nxt = w_len_zero;
                end else begin
                    w_cyc_nxt  = 1'b0;
                    w_done_nxt = 1'b0;
                end
            end
            ST_FETCH: begin
                if (w_last) begin
                    w_cyc_nxt  = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    w_cyc_nxt  = 1'b1;
                    w_done_nxt = 1'b0;
                end
            end
            default: begin
                w_cyc_nxt  = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs: bus cycle, line-buffer write port, status flags
    always_ff @(posedge dotclk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cyc     <= 1'b0;
            r_done    <= 1'b0;
            r_lb_we   <= 1'b0;
            r_lb_adr  <= '0;
            r_lb_dat  <= '0;
            r_overrun <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cyc   <= w_cyc_nxt;
            r_done  <= w_done_nxt;
            r_lb_we <= w_term;
            if (w_term) begin
                r_lb_adr <= {r_bank, r_idx};
                // Errored words are written as zero so the line stays aligned.
                r_lb_dat <= err_i ? {DW{1'b0}} : dat_i;
            end
            if (start_i && (r_state == ST_FETCH)) begin
                r_overrun <= 1'b1;
            end
            if (w_term && err_i) begin
                r_err <= 1'b1;
            end
        end
    end

    // Datapath: line pointer, bus address, word counter, bank and index
    always_ff @(posedge dotclk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ptr  <= '0;
            r_adr  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_bank <= 1'b0;
        end else begin
            // An empty line completes at once, so it advances from its own start.
            if (w_start_ok && w_len_zero) begin
                r_ptr <= w_line_adr + stride_i;
            end else if (frame_i) begin
                r_ptr <= base_adr_i;
            end else if (w_last) begin
                r_ptr <= r_ptr + stride_i;
            end
            if (w_start_ok) begin
                r_bank <= odd_i;
                r_cnt  <= len_i;
                r_idx  <= '0;
                if (!w_len_zero) begin
                    r_adr <= w_line_adr;
                end
            end else if (w_term) begin
                r_adr <= r_adr + AW'(1);
                r_cnt <= r_cnt - LBW'(1);
                r_idx <= r_idx + LBW'(1);
            end
        end
    end

    assign cyc_o     = r_cyc;
    assign stb_o     = r_cyc;
    assign we_o      = 1'b0;
    assign adr_o     = r_adr;
    assign lb_we_o   = r_lb_we;
    assign lb_adr_o  = r_lb_adr;
    assign lb_dat_o  = r_lb_dat;
    assign busy_o    = (r_state == ST_FETCH);
    assign done_o    = r_done;
    assign overrun_o = r_overrun;
    assign err_o     = r_err;

endmodule

// File: tb/tb_video_fetcher.sv
module tb_video_fetcher;

    logic        clk;
    logic        reset;
    logic        frame, start, odd;
    logic [23:0] base, stride;
    logic [7:0]  len;
    logic        cyc_o, stb_o, we_o;
    logic [23:0] adr_o;
    logic [15:0] dat_i;
    logic        ack_i, err_i;
    logic        lb_we_o;
    logic [8:0]  lb_adr_o;
    logic [15:0] lb_dat_o;
    logic        busy_o, done_o, overrun_o, err_o;

    int checks = 0;
    int errors = 0;

    // slave configuration
    int waits      = 0;
    int err_word   = -1;
    int word_no    = 0;
    int wcnt       = 0;
    logic stray_ack = 1'b0;

    // observation log
    logic [8:0]  wr_adr[$];
    logic [15:0] wr_dat[$];
    logic [23:0] term_adr[$];
    int done_cnt   = 0;
    int done_wr    = 0;
    int done_we    = 0;
    int cyc_rises  = 0;
    logic prev_cyc = 1'b0;

    video_fetcher dut (
        .dotclk_i(clk), .reset_i(reset), .frame_i(frame), .start_i(start),
        .odd_i(odd), .base_adr_i(base), .stride_i(stride), .len_i(len),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
        .lb_we_o(lb_we_o), .lb_adr_o(lb_adr_o), .lb_dat_o(lb_dat_o),
        .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word_data(input logic [23:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Wishbone slave: acks after 'waits' idle cycles, err on word 'err_word'
    initial begin
        ack_i = 1'b0; err_i = 1'b0; dat_i = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (stray_ack) begin
                ack_i = 1'b1; err_i = 1'b0;
            end else if (cyc_o && stb_o) begin
                if (wcnt >= waits) begin
                    ack_i = 1'b1;
                    err_i = (word_no == err_word);
                    dat_i = word_data(adr_o);
                    wcnt = 0;
                    word_no++;
                end else begin
                    ack_i = 1'b0; err_i = 1'b0;
                    wcnt++;
                end
            end else begin
                ack_i = 1'b0; err_i = 1'b0;
                wcnt = 0; word_no = 0;
            end
        end
    end

    // Monitor: log terminations, line-buffer writes, done pulses, cyc rises
    always @(negedge clk) begin
        if (reset) begin
            prev_cyc = 1'b0;
        end else begin
            if (cyc_o && stb_o && (ack_i || err_i)) term_adr.push_back(adr_o);
            if (lb_we_o) begin
                wr_adr.push_back(lb_adr_o);
                wr_dat.push_back(lb_dat_o);
            end
            if (done_o) begin
                done_cnt++;
                done_wr = wr_adr.size();
                done_we = lb_we_o;
            end
            if (cyc_o && !prev_cyc) cyc_rises++;
            prev_cyc = cyc_o;
        end
    end

    task automatic clear_log();
        wr_adr.delete(); wr_dat.delete(); term_adr.delete();
        done_cnt = 0; done_wr = 0; done_we = 0; cyc_rises = 0;
    endtask

    task automatic pulse_frame(input logic [23:0] b);
        @(posedge clk); #2;
        base = b; frame = 1'b1;
        @(posedge clk); #2;
        frame = 1'b0;
    endtask

    // returns 2 time units after the accepting edge
    task automatic pulse_start(input logic o, input logic [7:0] l);
        @(posedge clk); #2;
        start = 1'b1; odd = o; len = l;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            $display("FAIL wait_done: no done_o within %0d cycles (got 0, want 1)", budget);
            errors++;
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({cyc_o, stb_o, we_o, adr_o} !== 27'd0) begin
            $display("FAIL reset_bus: got %h want 0", {cyc_o, stb_o, we_o, adr_o}); errors++;
        end
        checks++;
        if ({lb_we_o, lb_adr_o, lb_dat_o} !== 26'd0) begin
            $display("FAIL reset_lb: got %h want 0", {lb_we_o, lb_adr_o, lb_dat_o}); errors++;
        end
        checks++;
        if ({busy_o, done_o, overrun_o, err_o} !== 4'd0) begin
            $display("FAIL reset_status: got %b want 0000", {busy_o, done_o, overrun_o, err_o}); errors++;
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_line();
        waits = 0; err_word = -1;
        pulse_frame(24'h000100);
        clear_log();
        pulse_start(1'b1, 8'd4);
        checks++;
        if ({cyc_o, stb_o, busy_o, adr_o} !== {3'b111, 24'h000100}) begin
            $display("FAIL basic_latency: got cyc/stb/busy/adr %b%b%b %h want 111 000100",
                     cyc_o, stb_o, busy_o, adr_o); errors++;
        end
        wait_done(50);
        checks++;
        if (wr_adr.size() != 4 || term_adr.size() != 4) begin
            $display("FAIL basic_count: got %0d writes %0d terms want 4 4", wr_adr.size(), term_adr.size()); errors++;
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic [23:0] ea;
                logic [8:0]  el;
                ea = 24'h000100 + 24'(k);
                el = {1'b1, 8'(k)};
                checks++;
                if (term_adr[k] !== ea || wr_adr[k] !== el || wr_dat[k] !== word_data(ea)) begin
                    $display("FAIL basic_word%0d: got adr %h lb_adr %h dat %h want %h %h %h",
                             k, term_adr[k], wr_adr[k], wr_dat[k], ea, el, word_data(ea)); errors++;
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_wr != 4 || done_we != 1) begin
            $display("FAIL basic_done: got cnt %0d at write %0d we %0d want 1 4 1", done_cnt, done_wr, done_we); errors++;
        end
        // next line must start at base + stride
        clear_log();
        pulse_start(1'b0, 8'd1);
        wait_done(50);
        checks++;
        if (term_adr.size() != 1 || term_adr[0] !== 24'h000140 || wr_adr[0] !== 9'h000) begin
            $display("FAIL basic_stride: got terms %0d adr %h lb_adr %h want 1 000140 000",
                     term_adr.size(), term_adr.size() ? term_adr[0] : 24'hx, wr_adr.size() ? wr_adr[0] : 9'hx); errors++;
        end
    endtask

    task automatic test_wait_states();
        waits = 2; err_word = -1;
        pulse_frame(24'h000800);
        clear_log();
        pulse_start(1'b0, 8'd3);
        wait_done(60);
        checks++;
        if (wr_adr.size() != 3 || cyc_rises != 1) begin
            $display("FAIL wait_count: got %0d writes %0d cyc rises want 3 1", wr_adr.size(), cyc_rises); errors++;
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic [23:0] ea;
                ea = 24'h000800 + 24'(k);
                checks++;
                if (wr_adr[k] !== {1'b0, 8'(k)} || wr_dat[k] !== word_data(ea)) begin
                    $display("FAIL wait_word%0d: got lb_adr %h dat %h want %h %h",
                             k, wr_adr[k], wr_dat[k], {1'b0, 8'(k)}, word_data(ea)); errors++;
                end
            end
        end
        waits = 0;
    endtask

    task automatic test_overrun();
        waits = 0; err_word = -1;
        checks++;
        if (overrun_o !== 1'b0) begin
            $display("FAIL overrun_pre: got %b want 0", overrun_o); errors++;
        end
        pulse_frame(24'h002000);
        clear_log();
        pulse_start(1'b1, 8'd8);
        repeat (3) @(posedge clk);
        pulse_start(1'b0, 8'd2);
        wait_done(60);
        repeat (4) @(posedge clk);
        checks++;
        if (overrun_o !== 1'b1 || done_cnt != 1 || wr_adr.size() != 8) begin
            $display("FAIL overrun: got flag %b done %0d writes %0d want 1 1 8", overrun_o, done_cnt, wr_adr.size()); errors++;
        end else begin
            checks++;
            if (wr_adr[7] !== 9'h107 || wr_dat[7] !== word_data(24'h002007)) begin
                $display("FAIL overrun_last: got lb_adr %h dat %h want 107 %h", wr_adr[7], wr_dat[7], word_data(24'h002007)); errors++;
            end
        end
    endtask

    task automatic test_bus_error();
        waits = 0; err_word = 2;
        checks++;
        if (err_o !== 1'b0) begin
            $display("FAIL err_pre: got %b want 0", err_o); errors++;
        end
        pulse_frame(24'h003000);
        clear_log();
        pulse_start(1'b0, 8'd4);
        wait_done(50);
        checks++;
        if (err_o !== 1'b1 || wr_adr.size() != 4 || done_cnt != 1) begin
            $display("FAIL err_flag: got err %b writes %0d done %0d want 1 4 1", err_o, wr_adr.size(), done_cnt); errors++;
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic [15:0] ed;
                ed = (k == 2) ? 16'h0000 : word_data(24'h003000 + 24'(k));
                checks++;
                if (wr_adr[k] !== {1'b0, 8'(k)} || wr_dat[k] !== ed) begin
                    $display("FAIL err_word%0d: got lb_adr %h dat %h want %h %h", k, wr_adr[k], wr_dat[k], {1'b0, 8'(k)}, ed); errors++;
                end
            end
        end
        err_word = -1;
    endtask

    task automatic test_wrap_and_empty();
        logic [23:0] exp_t[4];
        exp_t[0] = 24'hFFFFFE; exp_t[1] = 24'hFFFFFF; exp_t[2] = 24'h000000; exp_t[3] = 24'h000001;
        waits = 0;
        pulse_frame(24'hFFFFFE);
        clear_log();
        pulse_start(1'b1, 8'd4);
        wait_done(50);
        checks++;
        if (term_adr.size() != 4) begin
            $display("FAIL wrap_count: got %0d want 4", term_adr.size()); errors++;
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (term_adr[k] !== exp_t[k] || wr_dat[k] !== word_data(exp_t[k])) begin
                    $display("FAIL wrap_word%0d: got adr %h dat %h want %h %h", k, term_adr[k], wr_dat[k], exp_t[k], word_data(exp_t[k])); errors++;
                end
            end
        end
        // ptr now 0xFFFFFE + 0x40 = 0x00003E; empty line advances it to 0x00007E
        clear_log();
        pulse_start(1'b0, 8'd0);
        checks++;
        if (cyc_o !== 1'b0 || done_o !== 1'b1) begin
            $display("FAIL empty_done: got cyc %b done %b want 0 1", cyc_o, done_o); errors++;
        end
        @(posedge clk); #2;
        checks++;
        if (done_o !== 1'b0 || cyc_rises != 0 || done_cnt != 1) begin
            $display("FAIL empty_after: got done %b rises %0d cnt %0d want 0 0 1", done_o, cyc_rises, done_cnt); errors++;
        end
        clear_log();
        pulse_start(1'b0, 8'd1);
        wait_done(50);
        checks++;
        if (term_adr.size() != 1 || term_adr[0] !== 24'h00007E) begin
            $display("FAIL empty_stride: got %0d terms adr %h want 1 00007E",
                     term_adr.size(), term_adr.size() ? term_adr[0] : 24'hx); errors++;
        end
        // stray acks while idle must be ignored
        clear_log();
        stray_ack = 1'b1;
        repeat (4) @(posedge clk);
        stray_ack = 1'b0;
        repeat (2) @(posedge clk); #2;
        checks++;
        if (wr_adr.size() != 0 || done_cnt != 0 || err_o !== 1'b1) begin
            $display("FAIL stray_ack: got writes %0d done %0d err %b want 0 0 1", wr_adr.size(), done_cnt, err_o); errors++;
        end
    endtask

    task automatic test_reset_mid_fetch();
        waits = 0;
        pulse_frame(24'h000500);
        clear_log();
        pulse_start(1'b1, 8'd8);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({cyc_o, stb_o, busy_o, done_o} !== 4'b0000) begin
            $display("FAIL reset_async: got cyc/stb/busy/done %b want 0000", {cyc_o, stb_o, busy_o, done_o}); errors++;
        end
        checks++;
        if ({overrun_o, err_o, lb_we_o} !== 3'b000) begin
            $display("FAIL reset_sticky: got %b want 000", {overrun_o, err_o, lb_we_o}); errors++;
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        clear_log();
        pulse_start(1'b0, 8'd2);
        wait_done(50);
        checks++;
        if (term_adr.size() != 2 || term_adr[0] !== 24'h000000 || term_adr[1] !== 24'h000001 || done_cnt != 1) begin
            $display("FAIL reset_refetch: got %0d terms first %h done %0d want 2 000000 1",
                     term_adr.size(), term_adr.size() ? term_adr[0] : 24'hx, done_cnt); errors++;
        end
    endtask

    initial begin
        reset = 1'b0; frame = 1'b0; start = 1'b0; odd = 1'b0;
        base = 24'h000000; stride = 24'h000040; len = 8'd0;
        test_reset();
        test_basic_line();
        test_wait_states();
        test_overrun();
        test_bus_error();
        test_wrap_and_empty();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
